mem_responder: RTL and testbench
================================

# mem_responder

Responder end of the 8-word scratch-memory access protocol: accepts one read or write request at a time from an initiator (sequencer/datapath) over a valid/ready handshake, performs it on an internal word array, and returns a held response over a second valid/ready handshake. Sits between the compute-loop sequencer and storage, replacing direct combinational RAM access with a flow-controlled, stallable interface.

## Interface
- DEPTH, 8, number of implemented words (1..2**AW)
- AW, 3, address width
- DW, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_write  out  1  echo of req_write for this response
- resp_rdata  out  DW  read data, or stored value for writes
- resp_err  out  1  address out of range (req_addr >= DEPTH)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: capture write/addr/wdata into request registers, go ACCESS.
- ACCESS: req_ready=0. Exactly one cycle. At the closing edge:
  - in-range write: word[addr] <= stored value; resp_rdata <= stored value; resp_err <= 0.
  - in-range read: resp_rdata <= word[addr]; resp_err <= 0.
  - out-of-range (either kind): no array change; resp_rdata <= 0; resp_err <= 1.
  - resp_write <= captured write bit; resp_valid <= 1; go RESP.
- RESP: resp_valid=1, resp_rdata/resp_write/resp_err held stable. On resp_ready: resp_valid <= 0, go IDLE. No request accepted while in RESP (req_ready=0).
- Stored value = req_wdata, modified per Configuration.
- Array contents change only in ACCESS; reads in ACCESS see all earlier completed writes.
- Out-of-range check only meaningful when DEPTH < 2**AW; with DEPTH == 2**AW resp_err is constantly 0.

## Timing
- Reset (async assert, sync-safe deassert handled upstream): state=IDLE, req_ready=1, resp_valid=0, resp_write=0, resp_rdata=0, resp_err=0, busy=0, all array words = 0.
- Accept edge E (req_valid && req_ready). resp_valid rises at edge E+1. Minimum request-to-request spacing: 3 cycles (accept, access, response consumed with resp_ready already high).
- resp_ready held low: response held indefinitely; req_valid ignored.
- resp_ready high before resp_valid: no effect outside RESP.
- req_ready is a function of state only; never depends on req_valid.
- Reset during ACCESS: pending write discarded (array cleared anyway); no response produced.
- Reset during RESP: response dropped, resp_valid=0 asynchronously.

## Configuration
- MEM_RESP_LSB_CLR_EN defined: stored value = {req_wdata[DW-1:1], 1'b0}; bit 0 of every written word is forced to 0; resp_rdata for a write reflects the cleared bit.
- Undefined: stored value = req_wdata unchanged.
- Reads unaffected in both cases.

## Structure
- Shared package mem_resp_pkg: state enum (IDLE, ACCESS, RESP), default DEPTH/AW/DW constants.
- One sub-module mem_resp_ram: DEPTH x DW array, async active-low clear, synchronous write enable, combinational read port. FSM, request/response registers, range check and LSB clear live in mem_responder.

## Test plan
- Reset then read addr 5 -> resp_valid at E+1, resp_rdata=0x00000000, resp_err=0, resp_write=0.
- Write addr 2 data 0x12345677, then read addr 2 -> with MEM_RESP_LSB_CLR_EN both responses 0x12345676; without, both 0x12345677.
- Write 0xA5A5A5A4 to addr 7, hold resp_ready=0 for 10 cycles -> resp_valid/resp_rdata stable, req_ready=0, second req_valid ignored; release -> IDLE, second request then accepted.
- DEPTH=6: write addr 6 data 0xFFFFFFFE -> resp_err=1, resp_rdata=0; subsequent reads of addrs 0..5 return 0.
- Back-to-back: req_valid and resp_ready tied high, alternating write/read addr 0..7 -> one transaction every 3 cycles, each read returns the preceding write.
- Assert rst during ACCESS of write 0xDEADBEEE to addr 1 -> resp_valid stays 0; after release read addr 1 returns 0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and default sizing for the scratch-memory responder.
package mem_resp_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW    = 3;
  localparam int DEF_DW    = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/mem_resp_ram.sv
// DEPTH x DW word array: async active-low clear, synchronous write, combinational read.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          addr_ok;

  assign addr_ok = ({1'b0, addr} < DEPTH_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && addr_ok) begin
      mem[addr] <= wdata;
    end
  end

  // Unimplemented addresses read as zero instead of indexing past the array.
  always_comb begin
    rdata = '0;
    if (addr_ok) begin
      rdata = mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Responder for the 8-word scratch-memory protocol: request handshake, one access cycle, held response.
// Optional feature: define MEM_RESP_LSB_CLR_EN to force bit 0 of every written word to 0.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_write,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_write_q, resp_write_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          in_range;
  logic [DW-1:0] stored_value;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  assign in_range = ({1'b0, addr_q} < DEPTH_W);

`ifdef MEM_RESP_LSB_CLR_EN
  assign stored_value = {wdata_q[DW-1:1], 1'b0};
`else
  assign stored_value = wdata_q;
`endif

  assign ram_we = (state_q == ACCESS) && wr_q && in_range;

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (stored_value),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        resp_valid_d = 1'b1;
        resp_write_d = wr_q;
        if (in_range) begin
          resp_rdata_d = wr_q ? stored_value : ram_rdata;
          resp_err_d   = 1'b0;
        end else begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Ready depends on state alone so the initiator can never form a combinational loop.
  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a DEPTH=8 and a DEPTH=6 instance share one request/response stimulus.
module tb_mem_responder;

  typedef struct {
    logic        w;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        req_ready, resp_valid, resp_write, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        req_ready_6, resp_valid_6, resp_write_6, resp_err_6, busy_6;
  logic [31:0] resp_rdata_6;

  int vectors;
  int miscompares;

  exp_t        sb[$];
  logic [31:0] model8 [8];
  logic [31:0] model6 [6];

  mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  mem_responder #(.DEPTH(6)) dut6 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready_6),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_6),
    .resp_ready (resp_ready),
    .resp_write (resp_write_6),
    .resp_rdata (resp_rdata_6),
    .resp_err   (resp_err_6),
    .busy       (busy_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef MEM_RESP_LSB_CLR_EN
    return {x[31:1], 1'b0};
`else
    return x;
`endif
  endfunction

  // Reference behaviour of both instances; returns the expectation for the one being checked.
  task automatic predict(input logic w, input logic [2:0] a, input logic [31:0] d,
                         input bit chk6, output exp_t e);
    exp_t e8, e6;
    e8.w = w; e8.e = 1'b0;
    e6.w = w; e6.e = (a >= 3'd6);
    if (w) begin
      model8[a] = stored(d);
      e8.d = stored(d);
    end else begin
      e8.d = model8[a];
    end
    if (a >= 3'd6) begin
      e6.d = 32'h0;
    end else if (w) begin
      model6[a] = stored(d);
      e6.d = stored(d);
    end else begin
      e6.d = model6[a];
    end
    e = chk6 ? e6 : e8;
  endtask

  task automatic clear_models();
    for (int i = 0; i < 8; i++) model8[i] = 32'h0;
    for (int i = 0; i < 6; i++) model6[i] = 32'h0;
  endtask

  task automatic pop_compare(input string name, input bit chk6);
    exp_t e;
    logic        rw, re;
    logic [31:0] rd;
    rw = chk6 ? resp_write_6 : resp_write;
    re = chk6 ? resp_err_6   : resp_err;
    rd = chk6 ? resp_rdata_6 : resp_rdata;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s unexpected response rdata=%h", name, rd);
    end else begin
      e = sb.pop_front();
      if ({rw, re, rd} !== {e.w, e.e, e.d}) begin
        miscompares++;
        $display("[TB] FAIL %s got w=%b err=%b rdata=%h want w=%b err=%b rdata=%h",
                 name, rw, re, rd, e.w, e.e, e.d);
      end
    end
  endtask

  // One complete transaction with resp_ready already high; checks E+1 response latency.
  task automatic do_txn(input string name, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input bit chk6);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!req_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_ready got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    predict(w, a, d, chk6, e);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_early got resp_valid=%b want 0", name, resp_valid);
    end
    cyc = 0;
    while (resp_valid !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL %s_latency got %0d cycles want 1", name, cyc);
    end
    pop_compare(name, chk6);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    clear_models();
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, resp_valid, resp_write, resp_rdata, resp_err, busy, req_ready_6, resp_valid_6, busy_6}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got rr=%b rv=%b rw=%b rd=%h err=%b busy=%b want rr=1 rv=0 rw=0 rd=0 err=0 busy=0",
               req_ready, resp_valid, resp_write, resp_rdata, resp_err, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    do_txn("reset_read5", 1'b0, 3'd5, 32'h0, 1'b0);
  endtask

  task automatic test_depth6();
    do_txn("depth6_oob_write", 1'b1, 3'd6, 32'hFFFF_FFFE, 1'b1);
    for (int i = 0; i < 6; i++) begin
      do_txn("depth6_read", 1'b0, 3'(i), 32'h0, 1'b1);
    end
  endtask

  task automatic test_write_read();
    do_txn("write_a2", 1'b1, 3'd2, 32'h1234_5677, 1'b0);
    do_txn("read_a2", 1'b0, 3'd2, 32'h0, 1'b0);
  endtask

  task automatic test_hold();
    exp_t e;
    logic [31:0] first;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd7; req_wdata = 32'hA5A5_A5A4;
    predict(1'b1, 3'd7, 32'hA5A5_A5A4, 1'b0, e);
    sb.push_back(e);
    first = e.d;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; req_addr = 3'd7; req_wdata = 32'h0;
    @(negedge clk);
    pop_compare("hold_resp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({resp_valid, resp_rdata, req_ready} !== {1'b1, first, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL hold_stable got rv=%b rd=%h rr=%b want rv=1 rd=%h rr=0",
                 resp_valid, resp_rdata, req_ready, first);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL hold_release got rv=%b rr=%b want rv=0 rr=1", resp_valid, req_ready);
    end
    predict(1'b0, 3'd7, 32'h0, 1'b0, e);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_second got rv=%b want 1", resp_valid);
    end
    pop_compare("hold_second_read", 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int issued, popped, cyc, last;
    logic [31:0] d;
    issued = 0; popped = 0; cyc = 0; last = -1;
    resp_ready = 1'b1;
    while (popped < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resp_valid === 1'b1) begin
        pop_compare("b2b_resp", 1'b0);
        popped++;
      end
      if (req_ready === 1'b1 && issued < 16) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== 3) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing got %0d cycles want 3", cyc - last);
          end
        end
        last = cyc;
        d = 32'h5A00_0001 + (32'(issued / 2) << 8);
        req_valid = 1'b1;
        req_write = (issued % 2 == 0);
        req_addr  = 3'(issued / 2);
        req_wdata = d;
        predict(req_write, req_addr, d, 1'b0, e);
        sb.push_back(e);
        issued++;
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (popped != 16) begin
      miscompares++;
      $display("[TB] FAIL b2b_count got %0d responses want 16", popped);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_access();
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 32'hDEAD_BEEE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    clear_models();
    sb.delete();
    vectors++;
    if ({resp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rst_access_async got rv=%b busy=%b want 0 0", resp_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rst_access_noresp got rv=%b want 0", resp_valid);
      end
    end
    do_txn("rst_access_read1", 1'b0, 3'd1, 32'h0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_depth6();
    test_write_read();
    test_hold();
    test_back_to_back();
    test_reset_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
